// File: rtl/seq_packet_serializer.sv
// Serialises a multi-lane sequence packet into one sequence per cycle in ascending lane order,
// skipping lanes whose strobe is clear and tagging each sequence with its index within the job.
module seq_packet_serializer #(
  parameter int PACKET_SIZE = 4,
  parameter int LL_BITS     = 8,
  parameter int ML_BITS     = 8,
  parameter int OFFSET_BITS = 16,
  parameter int IDX_BITS    = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_valid,
  output logic                               i_ready,
  input  logic [PACKET_SIZE-1:0]             i_strb,
  input  logic [PACKET_SIZE*LL_BITS-1:0]     i_ll,
  input  logic [PACKET_SIZE*ML_BITS-1:0]     i_ml,
  input  logic [PACKET_SIZE*OFFSET_BITS-1:0] i_offset,
  input  logic [PACKET_SIZE*ML_BITS-1:0]     i_overlap,
  input  logic [PACKET_SIZE-1:0]             i_eoj,
  input  logic [PACKET_SIZE-1:0]             i_delim,
  output logic                               o_valid,
  input  logic                               o_ready,
  output logic [LL_BITS-1:0]                 o_ll,
  output logic [ML_BITS-1:0]                 o_ml,
  output logic [OFFSET_BITS-1:0]             o_offset,
  output logic [ML_BITS-1:0]                 o_overlap,
  output logic                               o_eoj,
  output logic                               o_delim,
  output logic [IDX_BITS-1:0]                o_seq_idx
);

  localparam int P     = PACKET_SIZE;
  localparam int SEL_W = (P > 1) ? $clog2(P) : 1;

  // Holding register: one packet plus the mask of lanes not yet handed to the output stage
  logic [P-1:0]             pend_q, pend_d;
  logic [P*LL_BITS-1:0]     ll_q, ll_d;
  logic [P*ML_BITS-1:0]     ml_q, ml_d;
  logic [P*OFFSET_BITS-1:0] off_q, off_d;
  logic [P*ML_BITS-1:0]     ov_q, ov_d;
  logic [P-1:0]             eoj_q, eoj_d;
  logic [P-1:0]             delim_q, delim_d;

  logic                   o_valid_q, o_valid_d;
  logic [LL_BITS-1:0]     o_ll_q, o_ll_d;
  logic [ML_BITS-1:0]     o_ml_q, o_ml_d;
  logic [OFFSET_BITS-1:0] o_off_q, o_off_d;
  logic [ML_BITS-1:0]     o_ov_q, o_ov_d;
  logic                   o_eoj_q, o_eoj_d;
  logic                   o_delim_q, o_delim_d;
  logic [IDX_BITS-1:0]    o_idx_q, o_idx_d;
  logic [IDX_BITS-1:0]    cnt_q, cnt_d;

  logic [LL_BITS-1:0]     lane_ll  [P];
  logic [ML_BITS-1:0]     lane_ml  [P];
  logic [OFFSET_BITS-1:0] lane_off [P];
  logic [ML_BITS-1:0]     lane_ov  [P];

  for (genvar gi = 0; gi < P; gi++) begin : g_lane
    assign lane_ll[gi]  = ll_q[gi*LL_BITS +: LL_BITS];
    assign lane_ml[gi]  = ml_q[gi*ML_BITS +: ML_BITS];
    assign lane_off[gi] = off_q[gi*OFFSET_BITS +: OFFSET_BITS];
    assign lane_ov[gi]  = ov_q[gi*ML_BITS +: ML_BITS];
  end

  logic [SEL_W-1:0] sel;
  logic             sel_found;
  logic             adv, load, accept, one_left;

  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    for (int i = 0; i < P; i++) begin
      if (pend_q[i] && !sel_found) begin
        sel       = i[SEL_W-1:0];
        sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    adv      = !o_valid_q || o_ready;
    load     = adv && (pend_q != '0);
    one_left = (pend_q != '0) && ((pend_q & (pend_q - P'(1))) == '0);
    i_ready  = (pend_q == '0) || (adv && one_left);
    accept   = i_valid && i_ready;

    pend_d    = pend_q;
    ll_d      = ll_q;
    ml_d      = ml_q;
    off_d     = off_q;
    ov_d      = ov_q;
    eoj_d     = eoj_q;
    delim_d   = delim_q;
    o_valid_d = o_valid_q;
    o_ll_d    = o_ll_q;
    o_ml_d    = o_ml_q;
    o_off_d   = o_off_q;
    o_ov_d    = o_ov_q;
    o_eoj_d   = o_eoj_q;
    o_delim_d = o_delim_q;
    o_idx_d   = o_idx_q;
    cnt_d     = cnt_q;

    if (load) begin
      pend_d    = pend_q & ~(P'(1) << sel);
      o_valid_d = 1'b1;
      o_ll_d    = lane_ll[sel];
      o_ml_d    = lane_ml[sel];
      o_off_d   = lane_off[sel];
      o_ov_d    = lane_ov[sel];
      o_eoj_d   = eoj_q[sel];
      o_delim_d = delim_q[sel];
      o_idx_d   = cnt_q;
      if (eoj_q[sel]) begin
        cnt_d = '0;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + IDX_BITS'(1);
      end
    end else if (adv) begin
      o_valid_d = 1'b0;
    end

    // A new packet overwrites the holding register after its last lane was read above
    if (accept) begin
      pend_d  = i_strb;
      ll_d    = i_ll;
      ml_d    = i_ml;
      off_d   = i_offset;
      ov_d    = i_overlap;
      eoj_d   = i_eoj;
      delim_d = i_delim;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q    <= '0;
      ll_q      <= '0;
      ml_q      <= '0;
      off_q     <= '0;
      ov_q      <= '0;
      eoj_q     <= '0;
      delim_q   <= '0;
      o_valid_q <= 1'b0;
      o_ll_q    <= '0;
      o_ml_q    <= '0;
      o_off_q   <= '0;
      o_ov_q    <= '0;
      o_eoj_q   <= 1'b0;
      o_delim_q <= 1'b0;
      o_idx_q   <= '0;
      cnt_q     <= '0;
    end else begin
      pend_q    <= pend_d;
      ll_q      <= ll_d;
      ml_q      <= ml_d;
      off_q     <= off_d;
      ov_q      <= ov_d;
      eoj_q     <= eoj_d;
      delim_q   <= delim_d;
      o_valid_q <= o_valid_d;
      o_ll_q    <= o_ll_d;
      o_ml_q    <= o_ml_d;
      o_off_q   <= o_off_d;
      o_ov_q    <= o_ov_d;
      o_eoj_q   <= o_eoj_d;
      o_delim_q <= o_delim_d;
      o_idx_q   <= o_idx_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_valid   = o_valid_q;
  assign o_ll      = o_ll_q;
  assign o_ml      = o_ml_q;
  assign o_offset  = o_off_q;
  assign o_overlap = o_ov_q;
  assign o_eoj     = o_eoj_q;
  assign o_delim   = o_delim_q;
  assign o_seq_idx = o_idx_q;

endmodule

// File: tb/tb_seq_packet_serializer.sv
// Directed cycle table plus a scoreboarded random stream for seq_packet_serializer; a second
// instance with a 3-bit index exercises counter saturation on the same stimulus.
module tb_seq_packet_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        i_ready, i_ready2;
  logic [3:0]  i_strb = '0;
  logic [31:0] i_ll = '0;
  logic [31:0] i_ml = '0;
  logic [63:0] i_offset = '0;
  logic [31:0] i_overlap = '0;
  logic [3:0]  i_eoj = '0;
  logic [3:0]  i_delim = '0;
  logic        o_valid, o_valid2;
  logic        o_ready = 1'b0;
  logic [7:0]  o_ll, o_ll2, o_ml, o_ml2, o_overlap, o_overlap2;
  logic [15:0] o_offset, o_offset2;
  logic        o_eoj, o_eoj2, o_delim, o_delim2;
  logic [15:0] o_seq_idx;
  logic [2:0]  o_seq_idx2;

  always #5 clk = ~clk;

  seq_packet_serializer dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i_strb(i_strb),
    .i_ll(i_ll), .i_ml(i_ml), .i_offset(i_offset), .i_overlap(i_overlap),
    .i_eoj(i_eoj), .i_delim(i_delim), .o_valid(o_valid), .o_ready(o_ready),
    .o_ll(o_ll), .o_ml(o_ml), .o_offset(o_offset), .o_overlap(o_overlap),
    .o_eoj(o_eoj), .o_delim(o_delim), .o_seq_idx(o_seq_idx)
  );

  seq_packet_serializer #(.IDX_BITS(3)) dut_sat (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready2), .i_strb(i_strb),
    .i_ll(i_ll), .i_ml(i_ml), .i_offset(i_offset), .i_overlap(i_overlap),
    .i_eoj(i_eoj), .i_delim(i_delim), .o_valid(o_valid2), .o_ready(o_ready),
    .o_ll(o_ll2), .o_ml(o_ml2), .o_offset(o_offset2), .o_overlap(o_overlap2),
    .o_eoj(o_eoj2), .o_delim(o_delim2), .o_seq_idx(o_seq_idx2)
  );

  typedef struct {
    bit        rst;
    bit        iv;
    bit [3:0]  strb;
    bit [31:0] ll;
    bit [63:0] off;
    bit [3:0]  eoj;
    bit        ordy;
    bit        x_ird;
    bit        x_ov;
    bit [7:0]  x_ll;
    bit [15:0] x_off;
    bit        x_eoj;
    bit [15:0] x_idx;
  } row_t;

  typedef struct packed {
    logic [7:0]  ll;
    logic [7:0]  ml;
    logic [15:0] off;
    logic [7:0]  ov;
    logic        eoj;
    logic        delim;
    logic [15:0] idx;
    logic [2:0]  idx3;
  } seq_t;

  row_t rows[$];
  seq_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pk8(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  function automatic logic [63:0] pk16(input int a, input int b, input int c, input int d);
    return {d[15:0], c[15:0], b[15:0], a[15:0]};
  endfunction

  task automatic r(input bit rs, input bit iv, input bit [3:0] strb, input bit [31:0] ll,
                   input bit [63:0] off, input bit [3:0] eoj, input bit ordy, input bit x_ird,
                   input bit x_ov, input bit [7:0] x_ll, input bit [15:0] x_off,
                   input bit x_eoj, input bit [15:0] x_idx);
    row_t t;
    t = '{rs, iv, strb, ll, off, eoj, ordy, x_ird, x_ov, x_ll, x_off, x_eoj, x_idx};
    rows.push_back(t);
  endtask

  function automatic seq_t cur_out();
    seq_t s;
    s = '{o_ll, o_ml, o_offset, o_overlap, o_eoj, o_delim, o_seq_idx, o_seq_idx2};
    return s;
  endfunction

  initial begin
    logic [31:0] pa, pb;
    logic [15:0] cnt16;
    logic [2:0]  cnt3;
    int          sent, pend;
    bit          prev_stall, exp_ird;
    seq_t        prev_out, s, e;

    // Single full packet, counter from 0, first sequence two edges after acceptance
    r(1,0,4'h0,0,0,0,1, 1,0,0,0,0,0);
    r(0,1,4'hF,pk8(1,2,3,4),0,0,1, 1,0,0,0,0,0);
    r(0,0,0,0,0,0,1, 0,0,0,0,0,0);
    r(0,0,0,0,0,0,1, 0,1,1,0,0,0);
    r(0,0,0,0,0,0,1, 0,1,2,0,0,1);
    r(0,0,0,0,0,0,1, 1,1,3,0,0,2);
    r(0,0,0,0,0,0,1, 1,1,4,0,0,3);
    r(0,0,0,0,0,0,1, 1,0,0,0,0,0);
    // Back-to-back full packets with no bubble
    pa = pk8(5,6,7,8);
    pb = pk8(9,10,11,12);
    r(0,1,4'hF,pa,0,0,1, 1,0,0,0,0,0);
    r(0,1,4'hF,pb,0,0,1, 0,0,0,0,0,0);
    r(0,1,4'hF,pb,0,0,1, 0,1,5,0,0,4);
    r(0,1,4'hF,pb,0,0,1, 0,1,6,0,0,5);
    r(0,1,4'hF,pb,0,0,1, 1,1,7,0,0,6);
    r(0,0,0,0,0,0,1, 0,1,8,0,0,7);
    r(0,0,0,0,0,0,1, 0,1,9,0,0,8);
    r(0,0,0,0,0,0,1, 0,1,10,0,0,9);
    r(0,0,0,0,0,0,1, 1,1,11,0,0,10);
    r(0,0,0,0,0,0,1, 1,1,12,0,0,11);
    r(0,0,0,0,0,0,1, 1,0,0,0,0,0);
    // Sparse strobe, then an all-zero strobe whose eoj bits must be ignored
    r(0,1,4'hA,0,pk16(10,20,30,40),0,1, 1,0,0,0,0,0);
    r(0,1,4'h0,0,0,4'hF,1, 0,0,0,0,0,0);
    r(0,1,4'h0,0,0,4'hF,1, 1,1,0,20,0,12);
    r(0,0,0,0,0,0,1, 1,1,0,40,0,13);
    r(0,0,0,0,0,0,1, 1,0,0,0,0,0);
    // Mid-job eoj restarts the index; includes a one-cycle stall
    r(1,0,0,0,0,0,1, 1,0,0,0,0,0);
    pb = pk8(4,5,6,7);
    r(0,1,4'h7,pk8(1,2,3,0),0,4'h2,1, 1,0,0,0,0,0);
    r(0,1,4'hF,pb,0,0,1, 0,0,0,0,0,0);
    r(0,1,4'hF,pb,0,0,1, 0,1,1,0,0,0);
    r(0,1,4'hF,pb,0,0,1, 1,1,2,0,1,1);
    r(0,0,0,0,0,0,0, 0,1,3,0,0,0);
    r(0,0,0,0,0,0,1, 0,1,3,0,0,0);
    r(0,0,0,0,0,0,1, 0,1,4,0,0,1);
    r(0,0,0,0,0,0,1, 0,1,5,0,0,2);
    r(0,0,0,0,0,0,1, 1,1,6,0,0,3);
    r(0,0,0,0,0,0,1, 1,1,7,0,0,4);
    r(0,0,0,0,0,0,1, 1,0,0,0,0,0);
    // Reset while two lanes pending and output held; nothing stale afterwards
    r(1,0,0,0,0,0,1, 1,0,0,0,0,0);
    r(0,1,4'hF,pk8(21,22,23,24),0,0,1, 1,0,0,0,0,0);
    r(0,0,0,0,0,0,1, 0,0,0,0,0,0);
    r(0,0,0,0,0,0,1, 0,1,21,0,0,0);
    r(0,0,0,0,0,0,0, 0,1,22,0,0,1);
    r(1,0,0,0,0,0,0, 1,0,0,0,0,0);
    r(0,0,0,0,0,0,1, 1,0,0,0,0,0);
    r(0,0,0,0,0,0,1, 1,0,0,0,0,0);
    r(0,1,4'h1,pk8(25,0,0,0),0,0,1, 1,0,0,0,0,0);
    r(0,0,0,0,0,0,1, 1,0,0,0,0,0);
    r(0,0,0,0,0,0,1, 1,1,25,0,0,0);
    r(0,0,0,0,0,0,1, 1,0,0,0,0,0);

    repeat (2) @(posedge clk);
    #1;
    foreach (rows[k]) begin
      rst       = rows[k].rst;
      i_valid   = rows[k].iv;
      i_strb    = rows[k].strb;
      i_ll      = rows[k].ll;
      i_offset  = rows[k].off;
      i_eoj     = rows[k].eoj;
      i_ml      = '0;
      i_overlap = '0;
      i_delim   = '0;
      o_ready   = rows[k].ordy;
      #1;
      chk($sformatf("row%0d i_ready", k), 64'(i_ready), 64'(rows[k].x_ird));
      chk($sformatf("row%0d o_valid", k), 64'(o_valid), 64'(rows[k].x_ov));
      if (rows[k].x_ov || rows[k].rst) begin
        chk($sformatf("row%0d o_ll", k), 64'(o_ll), 64'(rows[k].x_ll));
        chk($sformatf("row%0d o_offset", k), 64'(o_offset), 64'(rows[k].x_off));
        chk($sformatf("row%0d o_eoj", k), 64'(o_eoj), 64'(rows[k].x_eoj));
        chk($sformatf("row%0d o_seq_idx", k), 64'(o_seq_idx), 64'(rows[k].x_idx));
        chk($sformatf("row%0d sat_idx", k), 64'(o_seq_idx2),
            (rows[k].x_idx > 7) ? 64'd7 : 64'(rows[k].x_idx));
      end
      @(posedge clk);
      #1;
    end

    // Random stream against a scoreboard, o_ready toggling about half the time
    rst = 1'b1;
    i_valid = 1'b0;
    o_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cnt16 = '0;
    cnt3 = '0;
    sent = 0;
    prev_stall = 1'b0;
    prev_out = '0;
    for (int cyc = 0; cyc < 6000 && (sent < 200 || sb.size() != 0); cyc++) begin
      i_valid   = (sent < 200) && ($urandom_range(0, 3) != 0);
      i_strb    = 4'($urandom_range(0, 15));
      i_ll      = $urandom;
      i_ml      = $urandom;
      i_offset  = {$urandom, $urandom};
      i_overlap = $urandom;
      i_delim   = 4'($urandom_range(0, 15));
      for (int l = 0; l < 4; l++) i_eoj[l] = ($urandom_range(0, 31) == 0);
      o_ready   = 1'($urandom_range(0, 1));
      #1;
      pend = sb.size() - (o_valid ? 1 : 0);
      exp_ird = (pend == 0) || ((!o_valid || o_ready) && pend == 1);
      chk($sformatf("rnd%0d i_ready", cyc), 64'(i_ready), 64'(exp_ird));
      if (prev_stall) begin
        chk($sformatf("rnd%0d stall_valid", cyc), 64'(o_valid), 64'd1);
        chk($sformatf("rnd%0d stall_fields", cyc), 64'(cur_out()), 64'(prev_out));
      end
      if (o_valid && o_ready) begin
        if (sb.size() == 0) begin
          chk($sformatf("rnd%0d unexpected_seq", cyc), 64'(o_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          s = cur_out();
          chk($sformatf("rnd%0d seq", cyc), 64'(s), 64'(e));
        end
      end
      if (i_valid && i_ready) begin
        sent++;
        for (int l = 0; l < 4; l++) begin
          if (i_strb[l]) begin
            s = '{i_ll[l*8 +: 8], i_ml[l*8 +: 8], i_offset[l*16 +: 16], i_overlap[l*8 +: 8],
                  i_eoj[l], i_delim[l], cnt16, cnt3};
            sb.push_back(s);
            cnt16 = i_eoj[l] ? 16'd0 : ((cnt16 == 16'hFFFF) ? cnt16 : cnt16 + 16'd1);
            cnt3  = i_eoj[l] ? 3'd0 : ((cnt3 == 3'd7) ? cnt3 : cnt3 + 3'd1);
          end
        end
      end
      prev_stall = o_valid && !o_ready;
      prev_out = cur_out();
      @(posedge clk);
      #1;
    end
    chk("rnd packets_sent", 64'(sent), 64'd200);
    chk("rnd drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
